// File: rtl/riscv_alu_pkg.sv
// Shared constants for the ALU arbiter: operation selects, highest legal select
// and requester IDs.
package riscv_alu_pkg;

  localparam int SEL_W = 4;

  localparam logic [SEL_W-1:0] ADD        = 4'd0;
  localparam logic [SEL_W-1:0] SUB        = 4'd1;
  localparam logic [SEL_W-1:0] AND        = 4'd2;
  localparam logic [SEL_W-1:0] OR         = 4'd3;
  localparam logic [SEL_W-1:0] XOR        = 4'd4;
  localparam logic [SEL_W-1:0] UPPER_LOAD = 4'd5;
  localparam logic [SEL_W-1:0] SHIFT_L    = 4'd6;
  localparam logic [SEL_W-1:0] SHIFT_R    = 4'd7;
  localparam logic [SEL_W-1:0] SHIFT_RA   = 4'd8;

  localparam logic [SEL_W-1:0] OP_MAX = SHIFT_RA;

  localparam logic REQ_EXE = 1'b0;
  localparam logic REQ_AGU = 1'b1;

endpackage

// File: rtl/riscv_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not win
// last time gets the one-hot grant.
module riscv_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = enable & valid[0] & (~valid[1] | last_grant);
    grant[1] = enable & valid[1] & (~valid[0] | ~last_grant);
  end

endmodule

// File: rtl/riscv_alu_arb.sv
// Shares one combinational ALU between the execute stage (req0) and the
// address/branch helper (req1); results land in a one-entry tagged register.
module riscv_alu_arb #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    SEL_WIDTH  = 4,
  parameter logic [SEL_WIDTH-1:0]  OP_MAX     = SEL_WIDTH'(riscv_alu_pkg::OP_MAX)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_in1,
  input  logic [DATA_WIDTH-1:0] req0_in2,
  input  logic [DATA_WIDTH-1:0] req0_imm,
  input  logic [SEL_WIDTH-1:0]  req0_sel,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_in1,
  input  logic [DATA_WIDTH-1:0] req1_in2,
  input  logic [DATA_WIDTH-1:0] req1_imm,
  input  logic [SEL_WIDTH-1:0]  req1_sel,
  output logic [DATA_WIDTH-1:0] alu_in1,
  output logic [DATA_WIDTH-1:0] alu_in2,
  output logic [DATA_WIDTH-1:0] alu_imm,
  output logic [SEL_WIDTH-1:0]  alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err
);
  import riscv_alu_pkg::*;

  logic                  r_rsp_valid;
  logic                  r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;
  logic                  r_last_grant;

  logic                  w_can_accept;
  logic                  w_enable;
  logic [1:0]            w_grant;
  logic                  w_any_grant;
  logic                  w_illegal;

  // Drain and refill in the same cycle keeps one op per clock.
  assign w_can_accept = ~r_rsp_valid | rsp_ready;
  assign w_enable     = w_can_accept & ~rst;

  riscv_rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .enable     (w_enable),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  assign req0_ready  = w_grant[0];
  assign req1_ready  = w_grant[1];
  assign w_any_grant = |w_grant;

  // Idle bus is parked at zero / ADD so the ALU does not toggle.
  always_comb begin
    alu_in1 = '0;
    alu_in2 = '0;
    alu_imm = '0;
    alu_sel = SEL_WIDTH'(ADD);
    if (w_grant[0]) begin
      alu_in1 = req0_in1;
      alu_in2 = req0_in2;
      alu_imm = req0_imm;
      alu_sel = req0_sel;
    end else if (w_grant[1]) begin
      alu_in1 = req1_in1;
      alu_in2 = req1_in2;
      alu_imm = req1_imm;
      alu_sel = req1_sel;
    end
  end

  assign w_illegal = (alu_sel > OP_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= REQ_EXE;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_last_grant <= REQ_AGU;
    end else if (w_any_grant) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_grant[1];
      r_last_grant <= w_grant[1];
      r_rsp_data   <= w_illegal ? '0 : alu_out;
      r_rsp_err    <= w_illegal;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_riscv_alu_arb.sv
// Directed + randomized bench for riscv_alu_arb against a transaction-level
// model of the arbitration and response register.
module tb_riscv_alu_arb;
  import riscv_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_in1, req0_in2, req0_imm, req1_in1, req1_in2, req1_imm;
  logic [3:0]  req0_sel, req1_sel, alu_sel;
  logic [31:0] alu_in1, alu_in2, alu_imm, alu_out, rsp_data;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: the response register contents and who won last.
  bit          m_valid, m_id, m_err, m_last;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  riscv_alu_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_imm(req0_imm), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_imm(req1_imm), .req1_sel(req1_sel),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_imm(alu_imm), .alu_sel(alu_sel),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] s, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] im);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return im;
      4'd6:    return b << im[4:0];
      4'd7:    return b >> im[4:0];
      4'd8:    return $signed(b) >>> im[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Stand-in ALU driven by whatever the arbiter puts on the bus.
  always_comb alu_out = alu_f(alu_sel, alu_in1, alu_in2, alu_imm);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_data = '0; m_err = 0; m_last = 1;
  endtask

  task automatic chk_rsp();
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    chk("rsp_id",    {31'd0, rsp_id},    {31'd0, m_id});
    chk("rsp_data",  rsp_data,           m_data);
    chk("rsp_err",   {31'd0, rsp_err},   {31'd0, m_err});
  endtask

  // Called just after a rising edge with inputs already set; checks the grant
  // cycle, crosses one edge and checks the response register.
  task automatic step();
    int w;
    logic [3:0]  s;
    logic [31:0] a, b, im;
    #1;
    w = -1;
    if (!m_valid || rsp_ready) begin
      if (req0_valid && req1_valid) w = m_last ? 0 : 1;
      else if (req0_valid)          w = 0;
      else if (req1_valid)          w = 1;
    end
    s = 4'd0; a = '0; b = '0; im = '0;
    if (w == 0)      begin s = req0_sel; a = req0_in1; b = req0_in2; im = req0_imm; end
    else if (w == 1) begin s = req1_sel; a = req1_in1; b = req1_in2; im = req1_imm; end
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, (w == 0)});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, (w == 1)});
    chk("alu_sel", {28'd0, alu_sel}, {28'd0, s});
    chk("alu_in1", alu_in1, a);
    chk("alu_in2", alu_in2, b);
    chk("alu_imm", alu_imm, im);
    @(posedge clk);
    if (w >= 0) begin
      m_valid = 1; m_id = w[0]; m_last = w[0];
      m_err   = (s > 4'd8);
      m_data  = m_err ? 32'd0 : alu_f(s, a, b, im);
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    #1;
    chk_rsp();
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_in1 = '0; req0_in2 = '0; req0_imm = '0; req0_sel = ADD;
    req1_in1 = '0; req1_in2 = '0; req1_imm = '0; req1_sel = ADD;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk_rsp();
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    rst = 1'b0;

    // Single ADD op
    req0_valid = 1; req0_sel = ADD; req0_in1 = 5; req0_in2 = 7;
    step();
    chk("single_data", rsp_data, 32'd12);
    req0_valid = 0;
    step();

    // Contention: alternate one response per clock
    req0_valid = 1; req0_sel = SUB; req0_in1 = 10;    req0_in2 = 3;
    req1_valid = 1; req1_sel = XOR; req1_in1 = 'hF0;  req1_in2 = 'h0F;
    repeat (6) step();

    // Backpressure for 4 cycles, then release
    rsp_ready = 0;
    repeat (4) step();
    rsp_ready = 1;
    step();

    // Illegal op followed by a legal one
    req0_valid = 0; req1_sel = 4'b1011;
    step();
    chk("illegal_err", {31'd0, rsp_err}, 32'd1);
    req1_sel = ADD;
    step();
    req1_valid = 0;

    // Arithmetic shift path
    req0_valid = 1; req0_sel = SHIFT_RA; req0_in2 = 32'h8000_0000; req0_imm = 4;
    step();
    chk("shift_ra_data", rsp_data, 32'hF800_0000);

    // Asynchronous reset while a response is held and both request
    req1_valid = 1; rsp_ready = 0;
    step();
    rst = 1'b1;
    #1;
    chk("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("async_req1_ready", {31'd0, req1_ready}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0; rsp_ready = 1;
    step();
    chk("post_reset_id", {31'd0, rsp_id}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      rsp_ready  = ($urandom_range(0, 4) != 0);
      req0_sel = 4'($urandom_range(0, 15)); req1_sel = 4'($urandom_range(0, 15));
      req0_in1 = $urandom; req0_in2 = $urandom; req0_imm = $urandom;
      req1_in1 = $urandom; req1_in2 = $urandom; req1_imm = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
